// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Optional feature macro: ALU_ARB_LOCK_EN (lock ports for atomic multi-op sequences)
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out
);

  logic stage1_valid;
  logic owner;
  logic last_grant;
  logic grant0;
  logic grant1;

`ifdef ALU_ARB_LOCK_EN
  logic lock_active;
  logic lock_owner;
`endif

  // Grant never looks at the requester's own ctrl/operands, only at valids and history.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
`ifdef ALU_ARB_LOCK_EN
      if (lock_active) begin
        grant0 = req0_valid & ~lock_owner;
        grant1 = req1_valid & lock_owner;
      end else begin
        if (req0_valid && (!req1_valid || last_grant)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
      end
`else
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl     <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      stage1_valid <= 1'b0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_data     <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_active  <= 1'b0;
      lock_owner   <= 1'b0;
`endif
    end else begin
      // Operand registers only load on accept so the ALU inputs stay quiet when idle.
      if (grant0 || grant1) begin
        alu_ctrl     <= grant1 ? req1_ctrl : req0_ctrl;
        alu_a        <= grant1 ? req1_a    : req0_a;
        alu_b        <= grant1 ? req1_b    : req0_b;
        owner        <= grant1;
        last_grant   <= grant1;
        stage1_valid <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
        lock_active  <= grant1 ? req1_lock : req0_lock;
        lock_owner   <= grant1;
`endif
      end else begin
        stage1_valid <= 1'b0;
      end

      rsp0_valid <= stage1_valid & ~owner;
      rsp1_valid <= stage1_valid & owner;
      if (stage1_valid) begin
        rsp_data <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level model
// Optional feature macro: ALU_ARB_LOCK_EN
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_ctrl, req1_ctrl, alu_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data, alu_a, alu_b, alu_out;
`ifdef ALU_ARB_LOCK_EN
  logic        req0_lock, req1_lock;
`endif

  alu_arbiter #(.DATA_W(32), .CTRL_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_ctrl, alu_a, alu_b);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct { int port; logic [31:0] data; int due; } pend_t;
  typedef struct { int port; logic [31:0] data; int cyc; } obs_t;
  typedef struct { int port; int cyc; } gnt_t;

  pend_t pend[$];
  obs_t  obs[$];
  gnt_t  glog[$];

  int          cyc = 0;
  logic        m_prefer1;
  logic [31:0] m_data, m_a, m_b;
  logic [2:0]  m_ctrl;
  logic        m_locked;
  int          m_lock_owner;
  logic        eg0, eg1, ev0, ev1;
  pend_t       item;
  int          g;

  task automatic model_reset();
    pend.delete();
    m_prefer1    = 1'b0;
    m_data       = '0;
    m_a          = '0;
    m_b          = '0;
    m_ctrl       = '0;
    m_locked     = 1'b0;
    m_lock_owner = 0;
  endtask

  initial model_reset();

  // Model: round-robin preference, a queue of responses due two cycles after accept.
  always @(negedge clk) begin
    cyc++;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (m_locked) begin
        eg0 = req0_valid && (m_lock_owner == 0);
        eg1 = req1_valid && (m_lock_owner == 1);
      end else if (req0_valid && req1_valid) begin
        eg0 = !m_prefer1;
        eg1 = m_prefer1;
      end else begin
        eg0 = req0_valid;
        eg1 = req1_valid;
      end
    end
    check("ready0", {31'd0, req0_ready}, {31'd0, eg0});
    check("ready1", {31'd0, req1_ready}, {31'd0, eg1});

    ev0 = 1'b0;
    ev1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      item = pend.pop_front();
      ev0 = (item.port == 0);
      ev1 = (item.port == 1);
      m_data = item.data;
    end
    check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ev0});
    check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, ev1});
    check("rsp_data", rsp_data, m_data);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, m_ctrl});

    if (rsp0_valid === 1'b1) obs.push_back('{0, rsp_data, cyc});
    if (rsp1_valid === 1'b1) obs.push_back('{1, rsp_data, cyc});

    if (rst) begin
      model_reset();
    end else if (eg0 || eg1) begin
      g = eg1 ? 1 : 0;
      m_ctrl = eg1 ? req1_ctrl : req0_ctrl;
      m_a    = eg1 ? req1_a : req0_a;
      m_b    = eg1 ? req1_b : req0_b;
      pend.push_back('{g, alu_fn(m_ctrl, m_a, m_b), cyc + 2});
      glog.push_back('{g, cyc});
      m_prefer1 = (g == 0);
`ifdef ALU_ARB_LOCK_EN
      m_locked = eg1 ? req1_lock : req0_lock;
      m_lock_owner = g;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic expect_obs(input string name, input int idx, input int port, input logic [31:0] data);
    if (idx < obs.size()) begin
      check({name, "_port"}, obs[idx].port, port);
      check({name, "_data"}, obs[idx].data, data);
    end else begin
      check({name, "_present"}, obs.size(), idx + 1);
    end
  endtask

  task automatic expect_gnt(input string name, input int idx, input int port);
    if (idx < glog.size()) check(name, glog[idx].port, port);
    else check({name, "_present"}, glog.size(), idx + 1);
  endtask

  task automatic clear_logs();
    obs.delete();
    glog.delete();
  endtask

  initial begin
    rst = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    req0_lock = 1'b0;
    req1_lock = 1'b0;
`endif
    drive0(1'b0, OP_ADD, 0, 0);
    drive1(1'b0, OP_ADD, 0, 0);
    repeat (3) step();
    rst = 1'b0;

    // Single op on port 0
    clear_logs();
    drive0(1'b1, OP_ADD, 32'd5, 32'd7);
    @(negedge clk);
    check("t1_ready0", {31'd0, req0_ready}, 32'd1);
    step();
    idle();
    repeat (4) step();
    check("t1_count", obs.size(), 1);
    expect_obs("t1", 0, 0, 32'd12);
    if (obs.size() > 0 && glog.size() > 0) check("t1_latency", obs[0].cyc - glog[0].cyc, 2);

    // Back-to-back shifts on port 1
    clear_logs();
    drive1(1'b1, OP_SLL, 32'd1, 32'd4);
    step();
    drive1(1'b1, OP_SRA, 32'h8000_0000, 32'd4);
    step();
    drive1(1'b1, OP_SRL, 32'h8000_0000, 32'd4);
    step();
    idle();
    repeat (4) step();
    check("t3_count", obs.size(), 3);
    expect_obs("t3_sll", 0, 1, 32'h0000_0010);
    expect_obs("t3_sra", 1, 1, 32'hF800_0000);
    expect_obs("t3_srl", 2, 1, 32'h0800_0000);
    if (obs.size() == 3) check("t3_consecutive", obs[2].cyc - obs[0].cyc, 2);

    // Contention for four cycles
    clear_logs();
    drive0(1'b1, OP_SUB, 32'd10, 32'd3);
    drive1(1'b1, OP_XOR, 32'hF0, 32'hFF);
    repeat (4) step();
    idle();
    repeat (4) step();
    expect_gnt("t2_g0", 0, 0);
    expect_gnt("t2_g1", 1, 1);
    expect_gnt("t2_g2", 2, 0);
    expect_gnt("t2_g3", 3, 1);
    check("t2_count", obs.size(), 4);
    expect_obs("t2_r0", 0, 0, 32'd7);
    expect_obs("t2_r1", 1, 1, 32'h0F);
    expect_obs("t2_r2", 2, 0, 32'd7);
    expect_obs("t2_r3", 3, 1, 32'h0F);
    if (obs.size() == 4) check("t2_consecutive", obs[3].cyc - obs[0].cyc, 3);

    // Reset while an op is in flight
    clear_logs();
    drive0(1'b1, OP_AND, 32'hFF, 32'h0F);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    check("t4_no_rsp", obs.size(), 0);
    drive0(1'b1, OP_AND, 32'hFF, 32'h0F);
    drive1(1'b1, OP_OR, 32'd1, 32'd2);
    repeat (2) step();
    idle();
    repeat (4) step();
    expect_gnt("t4_first", 1, 0);
    expect_gnt("t4_second", 2, 1);
    expect_obs("t4_and", 0, 0, 32'h0F);
    expect_obs("t4_or", 1, 1, 32'd3);

    // Idle gaps: operands and result hold
    clear_logs();
    drive0(1'b1, OP_AND, 32'hFF, 32'h0F);
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    check("t5_gap_rsp0", {31'd0, rsp0_valid}, 32'd0);
    check("t5_gap_rsp1", {31'd0, rsp1_valid}, 32'd0);
    check("t5_hold_a", alu_a, 32'hFF);
    check("t5_hold_b", alu_b, 32'h0F);
    check("t5_hold_data", rsp_data, 32'h0F);
    step();
    drive1(1'b1, OP_ADD, 32'd1, 32'd1);
    step();
    idle();
    repeat (4) step();
    @(negedge clk);
    check("t5_after", rsp_data, 32'd2);
    expect_obs("t5_r1", 1, 1, 32'd2);

`ifdef ALU_ARB_LOCK_EN
    // Locked sequence on port 0 while port 1 keeps requesting
    step();
    clear_logs();
    drive1(1'b1, OP_XOR, 32'h3, 32'h5);
    drive0(1'b1, OP_ADD, 32'd1, 32'd2);
    req0_lock = 1'b1;
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("lk_owner_idle_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    drive0(1'b1, OP_ADD, 32'd3, 32'd4);
    req0_lock = 1'b0;
    @(negedge clk);
    check("lk_unlock_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("lk_release_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    idle();
    repeat (4) step();
    expect_gnt("lk_g0", 0, 0);
    expect_gnt("lk_g1", 1, 0);
    expect_gnt("lk_g2", 2, 1);
    expect_obs("lk_r0", 0, 0, 32'd3);
    expect_obs("lk_r1", 1, 0, 32'd7);
    expect_obs("lk_r2", 2, 1, 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 3-bit-controlled 32-bit ALU between two requesters: port 0 is the integer pipe and port 1 is the address/branch unit.
- Arbitrates round-robin and registers the winning operation into the ALU operand stage.
- Captures the ALU result one cycle later and returns it to the owning requester with a valid pulse.
- Sits between the decode/issue logic and the ALU instance.

Parameters:
- DATA_W, 32, operand/result width; must match ALU width.
- CTRL_W, 3, ALU operation code width; codes are the header/macro.vh ALU macros (`ADD, `SUB, `AND, `OR, `XOR, `SLL, `SRA, `SRL).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_ctrl  in  CTRL_W  requester 0 opcode
- req0_a, req0_b  in  DATA_W  requester 0 operands
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b  same as port 0, for requester 1
- rsp0_valid  out  1  one-cycle pulse: rsp_data belongs to requester 0
- rsp1_valid  out  1  one-cycle pulse: rsp_data belongs to requester 1
- rsp_data  out  DATA_W  registered ALU result
- alu_ctrl  out  CTRL_W  registered opcode to ALU
- alu_a, alu_b  out  DATA_W  registered operands to ALU
- alu_out  in  DATA_W  combinational ALU result

Behaviour:
- Clocking: one clock domain, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values:
  - alu_ctrl=0, alu_a=0, alu_b=0
  - stage1_valid=0, owner=0, last_grant=1 (port 0 wins first contention)
  - rsp0_valid=0, rsp1_valid=0, rsp_data=0
  - req*_ready=0 while rst=1
- Arbitration is combinational and evaluated every cycle:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the port not equal to last_grant.
  - Neither valid: no grant.
- req_ready is asserted only for the granted port and never for both. It depends on other-port valid and last_grant, never on the port's own ctrl/operands.
- Accept cycle N (valid&ready on port g):
  - alu_ctrl/alu_a/alu_b <= port g fields.
  - owner <= g, stage1_valid <= 1, last_grant <= g.
- No accept in cycle N:
  - stage1_valid <= 0.
  - Operand registers hold their value (no toggling, for power).
- Cycle N+1: if stage1_valid, then rsp_data <= alu_out and rsp{owner}_valid <= 1 for exactly one cycle. Otherwise both rsp valids are 0 and rsp_data holds.
- Latency: rsp valid is visible in cycle N+2 after the accept edge, i.e. 2 clocks accept-to-response. Throughput is 1 op/cycle; back-to-back accepts produce back-to-back responses in order.
- No response backpressure: requesters must sink rsp on the pulse.
- Requester rule: a requester holding valid without ready must keep ctrl/a/b stable. The arbiter does not check this.
- Undefined opcodes (outside the 8 macros) are forwarded unchanged. rsp_data is whatever the ALU drives and is not checked.
- Shifts: B is forwarded full width; shift amount semantics belong to the ALU.
- Reset mid-operation: any in-flight stage1/rsp operation is discarded with no response pulse. Round-robin state restarts at last_grant=1.
- Simultaneous accept on one port and response on the other is legal; each port sees its own pulse.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - Adds inputs req0_lock and req1_lock (1 bit each) and state lock_active / lock_owner.
  - Accepting an op with lock=1 sets lock_active=1 and lock_owner=g.
  - While lock_active, only lock_owner can be granted; the other port sees ready=0 even if the owner is idle.
  - Accepting an op from lock_owner with lock=0 clears lock_active after that op. This gives atomic multi-op sequences.
  - rst clears lock_active.
- Undefined: lock ports and lock state do not exist; pure round-robin as above.

Test Plan:
- After reset, req0 only: ctrl=`ADD, a=5, b=7. Required: req0_ready=1 in the same cycle; rsp0_valid=1 with rsp_data=12 two clocks later; rsp1_valid stays 0.
- Both valid for 4 cycles:
  - Port 0 always ctrl=`SUB, a=10, b=3. Port 1 always ctrl=`XOR, a=0xF0, b=0xFF.
  - Required grants: 0,1,0,1.
  - Required responses: 7, 0x0F, 7, 0x0F, alternating rsp0_valid/rsp1_valid on consecutive cycles.
- Back-to-back on port 1: `SLL(1,4), `SRA(0x80000000,4), `SRL(0x80000000,4). Required: rsp1 pulses on 3 consecutive cycles with data 0x10, 0xF8000000, 0x08000000.
- Assert rst one cycle after an accept of `AND(0xFF,0x0F). Required: no rsp pulse. After release, contention grants port 0 first.
- Idle cycle between ops. Required:
  - Response valid is low in the matching gap.
  - alu_a/alu_b hold the previous values.
  - rsp_data holds 0x0F from a prior `AND(0xFF,0x0F).
- (ALU_ARB_LOCK_EN) Port 0 issues `ADD lock=1, then `ADD lock=0, while port 1 is valid throughout. Required: port 1 ready=0 until port 0's lock=0 op is accepted, then port 1 is granted on the next cycle.
